// File: rtl/instruction_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_pkg : shared fetch-stage types and constants
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package instruction_fetch_unit_pkg;

    localparam int c_addr_w  = 8;
    localparam int c_instr_w = 8;

    localparam logic [c_instr_w-1:0] c_nop_default     = 8'h00;
    localparam logic [c_instr_w-1:0] c_halt_op_default = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [c_instr_w-1:0] instruction;
        logic [c_addr_w-1:0]  pc_plus1;
        logic                 valid;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_if_id_register.sv
// ----------------------------------------------------------------------------
// if_id_register : 17-bit IF/ID pipeline register with flush/hold/load
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [c_instr_w-1:0] NOP = c_nop_default
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_load,
    input  logic   i_flush,
    input  logic   i_hold,
    input  if_id_t i_data,
    output if_id_t o_data
);

    localparam if_id_t c_bubble = '{instruction: NOP, pc_plus1: '0, valid: 1'b0};

    if_id_t data_q;
    if_id_t data_d;

    // Flush wins over hold so a redirect always squashes a stalled word.
    always_comb begin
        data_d = data_q;
        if (i_flush) begin
            data_d = c_bubble;
        end else if (i_hold) begin
            data_d = data_q;
        end else if (i_load) begin
            data_d = i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= c_bubble;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit : PC, fetch FSM and IF/ID register driving imem
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                   PROG_LEN = 6,
    parameter logic [c_instr_w-1:0] NOP      = c_nop_default,
    parameter logic [c_instr_w-1:0] HALT_OP  = c_halt_op_default
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [c_addr_w-1:0]  branch_target,
    output logic [c_addr_w-1:0]  address,
    input  logic [c_instr_w-1:0] instruction,
    output logic [c_instr_w-1:0] if_id_instruction,
    output logic [c_addr_w-1:0]  if_id_pc_plus1,
    output logic                 if_id_valid,
    output logic                 halted
);

    localparam logic [c_addr_w:0]   c_prog_len = (c_addr_w+1)'(PROG_LEN);
    localparam logic [c_addr_w-1:0] c_last_pc  = c_addr_w'(PROG_LEN - 1);

    fetch_state_e        state_q, state_d;
    logic [c_addr_w-1:0] pc_q, pc_d;
    logic [c_addr_w-1:0] w_pc_plus1;
    logic                w_load, w_flush, w_hold;
    if_id_t              w_if_id_in, w_if_id_out;

    assign w_pc_plus1 = pc_q + 8'd1;
    assign w_if_id_in = '{instruction: instruction, pc_plus1: w_pc_plus1, valid: 1'b1};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        w_load  = 1'b0;
        w_flush = 1'b0;
        w_hold  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_flush = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A PC outside the program (only reachable by a branch) stops fetch.
                if ({1'b0, pc_q} >= c_prog_len) begin
                    w_hold  = 1'b1;
                    state_d = ST_HALT;
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    w_flush = 1'b1;
                end else if (instruction == HALT_OP) begin
                    w_load  = 1'b1;
                    state_d = ST_HALT;
                end else if (stall) begin
                    w_hold  = 1'b1;
                end else if (pc_q == c_last_pc) begin
                    w_load  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    w_load  = 1'b1;
                    pc_d    = w_pc_plus1;
                end
            end
            ST_HALT: begin
                w_hold = 1'b1;
            end
            default: begin
                w_flush = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_register #(
        .NOP (NOP)
    ) u_if_id_register (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_hold  (w_hold),
        .i_data  (w_if_id_in),
        .o_data  (w_if_id_out)
    );

    // The last word keeps its stored valid bit, but a halted stage reports nothing valid.
    assign address           = pc_q;
    assign halted            = (state_q == ST_HALT);
    assign if_id_instruction = w_if_id_out.instruction;
    assign if_id_pc_plus1    = w_if_id_out.pc_plus1;
    assign if_id_valid       = w_if_id_out.valid & ~halted;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit : directed + randomized checks against a fetch model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_unit;

    localparam int          PROG_LEN = 6;
    localparam logic [7:0]  NOP      = 8'h00;
    localparam logic [7:0]  HALT_OP  = 8'hFF;
    localparam int          P_WARM   = 0;
    localparam int          P_RUN    = 1;
    localparam int          P_STOP   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic [7:0] address;
    logic [7:0] instruction;
    logic [7:0] if_id_instruction;
    logic [7:0] if_id_pc_plus1;
    logic       if_id_valid;
    logic       halted;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    assign instruction = mem[address];

    instruction_fetch_unit #(
        .PROG_LEN (PROG_LEN),
        .NOP      (NOP),
        .HALT_OP  (HALT_OP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .address           (address),
        .instruction       (instruction),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus1    (if_id_pc_plus1),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected architectural view of the fetch stage
    int m_phase, m_pc, m_ins, m_pp1, m_valid;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("address", int'(address), m_pc);
        chk("if_id_instruction", int'(if_id_instruction), m_ins);
        chk("if_id_pc_plus1", int'(if_id_pc_plus1), m_pp1);
        chk("if_id_valid", int'(if_id_valid), m_valid);
        chk("halted", int'(halted), (m_phase == P_STOP) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_phase = P_WARM;
        m_pc    = 0;
        m_ins   = int'(NOP);
        m_pp1   = 0;
        m_valid = 0;
    endtask

    task automatic model_step();
        int w;
        if (m_phase == P_WARM) begin
            m_phase = P_RUN;
            m_ins   = int'(NOP);
            m_pp1   = 0;
            m_valid = 0;
        end else if (m_phase == P_RUN) begin
            w = int'(mem[m_pc]);
            if (m_pc >= PROG_LEN) begin
                m_phase = P_STOP;
                m_valid = 0;
            end else if (branch_taken) begin
                m_pc    = int'(branch_target);
                m_ins   = int'(NOP);
                m_pp1   = 0;
                m_valid = 0;
            end else if (w == int'(HALT_OP)) begin
                m_ins   = w;
                m_pp1   = (m_pc + 1) % 256;
                m_phase = P_STOP;
                m_valid = 0;
            end else if (!stall) begin
                m_ins = w;
                m_pp1 = (m_pc + 1) % 256;
                if (m_pc == PROG_LEN - 1) begin
                    m_phase = P_STOP;
                    m_valid = 0;
                end else begin
                    m_valid = 1;
                    m_pc    = m_pp1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic s, input logic b, input int t);
        stall         = s;
        branch_taken  = b;
        branch_target = 8'(t);
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < PROG_LEN) ? 8'(17 * (i + 1)) : 8'h5A;
        end
    endtask

    // Called at a falling edge; releases reset at the following falling edge.
    task automatic hard_reset();
        set_in(1'b0, 1'b0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        load_default();
        model_reset();
        @(negedge clk);
        compare_all();
        chk("reset_address", int'(address), 0);
        chk("reset_valid", int'(if_id_valid), 0);
        reset = 1'b0;

        // Straight-line program run
        tick();
        chk("warmup_valid", int'(if_id_valid), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("seq_instr", int'(if_id_instruction), 17 * (k + 1));
        end
        chk("seq_halted", int'(halted), 1);
        chk("seq_addr", int'(address), 5);
        set_in(1'b0, 1'b1, 2);
        tick();
        tick();
        chk("halt_ignores_branch", int'(address), 5);

        // Stall hold, then branch with stall
        hard_reset();
        tick();
        tick();
        tick();
        chk("pre_stall_addr", int'(address), 2);
        chk("pre_stall_instr", int'(if_id_instruction), 8'h22);
        set_in(1'b1, 1'b0, 0);
        tick();
        tick();
        chk("stall_addr", int'(address), 2);
        chk("stall_instr", int'(if_id_instruction), 8'h22);
        chk("stall_pp1", int'(if_id_pc_plus1), 2);
        set_in(1'b0, 1'b0, 0);
        tick();
        chk("post_stall_instr", int'(if_id_instruction), 8'h33);
        tick();
        chk("pre_branch_addr", int'(address), 4);
        set_in(1'b1, 1'b1, 1);
        tick();
        chk("branch_addr", int'(address), 1);
        chk("branch_valid", int'(if_id_valid), 0);
        chk("branch_instr", int'(if_id_instruction), 0);
        set_in(1'b0, 1'b0, 0);
        tick();
        chk("post_branch_instr", int'(if_id_instruction), 8'h22);
        chk("post_branch_valid", int'(if_id_valid), 1);

        // Asynchronous reset between edges at PC=3
        tick();
        chk("pre_reset_addr", int'(address), 3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_reset_addr", int'(address), 0);
        chk("async_reset_instr", int'(if_id_instruction), 0);
        #1 reset = 1'b0;
        tick();
        tick();
        chk("restart_instr", int'(if_id_instruction), 8'h11);

        // Branch beyond the program
        set_in(1'b0, 1'b1, 9);
        tick();
        chk("oob_addr", int'(address), 9);
        chk("oob_not_halted", int'(halted), 0);
        set_in(1'b0, 1'b0, 0);
        tick();
        chk("oob_halted", int'(halted), 1);
        chk("oob_valid", int'(if_id_valid), 0);
        tick();

        // HALT_OP in the middle of the program
        mem[3] = HALT_OP;
        hard_reset();
        for (int k = 0; k < 4; k++) tick();
        tick();
        chk("haltop_instr", int'(if_id_instruction), 8'hFF);
        chk("haltop_halted", int'(halted), 1);
        chk("haltop_addr", int'(address), 3);
        set_in(1'b0, 1'b1, 0);
        tick();
        chk("haltop_branch_ignored", int'(address), 3);
        load_default();

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = ($urandom_range(0, 9) == 0) ? HALT_OP : 8'($urandom);
            end
            hard_reset();
            for (int c = 0; c < 30; c++) begin
                set_in(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 9)));
                if ($urandom_range(0, 24) == 0) begin
                    #2 reset = 1'b1;
                    #1;
                    model_reset();
                    compare_all();
                    #1 reset = 1'b0;
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter PROG_LEN, default 6: number of valid instruction words; fetch address range 0..PROG_LEN-1.
REQ-002 Parameter NOP, default 8'h00: instruction word inserted into IF/ID on flush or bubble.
REQ-003 Parameter HALT_OP, default 8'hFF: instruction word that stops fetch.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-007 branch_taken  input  1  redirect request from a later stage.
REQ-008 branch_target  input  8  redirect address, valid when branch_taken=1.
REQ-009 address  output  8  instruction memory read address; equals PC combinationally.
REQ-010 instruction  input  8  instruction memory read data; combinational in address, sampled at clk edge.
REQ-011 if_id_instruction  output  8  IF/ID register, instruction word.
REQ-012 if_id_pc_plus1  output  8  IF/ID register, fetch PC + 1.
REQ-013 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-014 halted  output  1  fetch stopped by HALT_OP or end of program.

Function
REQ-015 FSM states: IDLE, RUN, HALT; IDLE is the reset state.
REQ-016 IDLE: address=0, no IF/ID load except bubble; next cycle goes to RUN unconditionally (one warm-up cycle after reset release).
REQ-017 RUN priority per cycle: branch_taken > stall > normal fetch.
REQ-018 RUN normal: PC <= PC+1; IF/ID <= {instruction, PC+1, valid=1}.
REQ-019 RUN stall (no branch): PC, if_id_instruction, if_id_pc_plus1, if_id_valid all hold.
REQ-020 RUN branch_taken (stall ignored): PC <= branch_target; IF/ID <= {NOP, 0, valid=0} (one-cycle flush).
REQ-021 Fetch latency: word at address A appears on if_id_instruction exactly one clk edge after PC=A in RUN with no stall/branch.
REQ-022 PC arithmetic is 8-bit unsigned modulo 256; PC+1 from 8'hFF wraps to 8'h00.
REQ-023 If the sampled instruction equals HALT_OP in RUN (no branch): IF/ID loads it with valid=1, PC holds, state -> HALT.
REQ-024 If PC = PROG_LEN-1 in RUN (no branch, no stall): that word is loaded normally, PC holds, state -> HALT.
REQ-025 branch_target >= PROG_LEN: PC is loaded, next cycle goes to HALT without loading IF/ID, if_id_valid=0.
REQ-026 HALT: PC and address hold, if_id_valid=0 from the first HALT cycle onward, halted=1; only reset exits HALT; stall and branch_taken are ignored.
REQ-027 halted=1 exactly when state is HALT; 0 otherwise.

Reset
REQ-028 reset=1 asynchronously forces: state=IDLE, PC=0, address=0, if_id_instruction=NOP, if_id_pc_plus1=0, if_id_valid=0, halted=0.
REQ-029 Reset asserted mid-operation (any state, any stall/branch input) takes effect immediately, without waiting for clk; in-flight IF/ID contents are discarded.
REQ-030 First state update after reset deassertion is IDLE->RUN at the next rising clk.

Structure
REQ-031 Shared package holds: FSM state encoding, NOP and HALT_OP defaults, 8-bit address/instruction width constants.
REQ-032 One sub-module, if_id_register: 17-bit register with load, flush and hold controls and asynchronous reset; the PC register and FSM live in the top level.
REQ-033 No memory inside this block; it drives the existing 8-bit combinational instruction memory.

Verification
REQ-034 Memory {11,22,33,44,55,66}, no stall/branch -> after reset release: warm-up cycle, then if_id_instruction 11,22,33,44,55,66 on successive edges; halted=1 after 66, address stays 5.
REQ-035 stall=1 for 2 cycles while PC=2 -> PC stays 2, IF/ID holds 22 with pc_plus1=2, then 33 follows.
REQ-036 branch_taken=1, target=1 with stall=1 at PC=4 -> next edge PC=1, if_id_valid=0, instruction=NOP; following edge loads 22.
REQ-037 Word at address 3 = 8'hFF -> IF/ID loads FF with valid=1, halted=1 next edge, PC stays 3; later branch_taken ignored.
REQ-038 reset pulse between clk edges during RUN at PC=3 -> outputs reach reset values before the next edge; the fetch sequence restarts from address 0.
REQ-039 branch_target=8'h09 (>= PROG_LEN) -> PC=9, next edge halted=1, if_id_valid=0.
